// File: rtl/sdrx_pkg.sv
// Shared types, constants and helpers for the SD/eMMC data-block receiver.
package sdrx_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_CRC  = 3'd3,
        S_END  = 3'd4
    } state_t;

    localparam logic [15:0] CRC_POLYNOMIAL = 16'h1021;

    // Bus width codes as presented on i_width (2'b11 behaves like 8 lanes)
    localparam logic [1:0] W1 = 2'b00;
    localparam logic [1:0] W4 = 2'b01;
    localparam logic [1:0] W8 = 2'b10;

    // Number of strobe samples that fill one 32-bit word
    function automatic logic [5:0] samples_per_word(input logic [1:0] width);
        logic [5:0] spw;
        case (width)
            W1:      spw = 6'd32;
            W4:      spw = 6'd8;
            default: spw = 6'd4;
        endcase
        return spw;
    endfunction

    // Active-lane mask; inactive lanes never influence start, data, CRC or end bit
    function automatic logic [7:0] lane_mask(input logic [1:0] width);
        logic [7:0] m;
        case (width)
            W1:      m = 8'h01;
            W4:      m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // One serial CRC16 step; the received CRC bits are fed through too, so a good block ends at zero
    function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLYNOMIAL : 16'h0000);
    endfunction

endpackage

// File: rtl/sdrx_crc16.sv
// One lane/edge CRC16 accumulator with clear, step enable and a nonzero flag.
module sdrx_crc16
    import sdrx_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_step,
    input  logic i_bit,
    output logic o_nonzero
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    // Clear wins over step so a new block always starts from a zero remainder
    always_comb begin
        crc_d = crc_q;
        if (i_clr) begin
            crc_d = 16'h0000;
        end else if (i_step) begin
            crc_d = crc16_next(crc_q, i_bit);
        end else begin
            crc_d = crc_q;
        end
    end

    // CRC register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            crc_q <= 16'h0000;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign o_nonzero = |crc_q;

endmodule

// File: rtl/sdrx_frame.sv
// Host-side SD/eMMC data-block receiver: start bit, MSB-first word packing,
// per-lane/per-edge CRC16 check and end-bit check.
module sdrx_frame
    import sdrx_pkg::*;
#(
    parameter int LGLEN     = 7,
    parameter int LGTIMEOUT = 20
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_en,
    input  logic                 i_start,
    input  logic [1:0]           i_width,
    input  logic                 i_ddr,
    input  logic [LGLEN-1:0]     i_len,
    input  logic [LGTIMEOUT-1:0] i_timeout,
    input  logic                 i_pedge,
    input  logic                 i_nedge,
    input  logic [7:0]           i_dat,
    output logic                 o_valid,
    output logic [31:0]          o_data,
    output logic                 o_last,
    output logic                 o_done,
    output logic                 o_crc_err,
    output logic                 o_end_err,
    output logic                 o_timeout,
    output logic                 o_busy
);

    state_t                 state_q, state_d;
    logic [1:0]             width_q, width_d;
    logic                   ddr_q, ddr_d;
    logic [LGLEN:0]         len_q, len_d;
    logic [LGTIMEOUT-1:0]   tmo_q, tmo_d;
    logic [LGLEN:0]         word_cnt_q, word_cnt_d;
    logic [5:0]             samp_cnt_q, samp_cnt_d;
    logic [5:0]             crc_cnt_q, crc_cnt_d;
    logic                   pad_q, pad_d;
    logic [31:0]            shift_q, shift_d;
    logic                   valid_q, valid_d;
    logic [31:0]            data_q, data_d;
    logic                   last_q, last_d;
    logic                   done_q, done_d;
    logic                   crc_err_q, crc_err_d;
    logic                   end_err_q, end_err_d;
    logic                   timeout_q, timeout_d;
    logic                   busy_q, busy_d;

    logic [7:0]             mask_s;
    logic                   pos_s, neg_s, sample_s;
    logic                   arm_s, abort_s, start_s, tmo_hit_s;
    logic                   data_take_s, word_done_s, last_word_s;
    logic                   crc_take_s, crc_done_s, end_take_s, end_bad_s;
    logic [LGTIMEOUT-1:0]   tmo_next_s;
    logic [LGLEN:0]         word_inc_s;
    logic [31:0]            shift_next_s;
    logic [15:0]            crc_step_s;
    logic [15:0]            crc_nz_s;

    // A falling-edge strobe only counts in DDR and only when no rising strobe shares the cycle
    assign mask_s      = lane_mask(width_q);
    assign pos_s       = i_pedge;
    assign neg_s       = ~i_pedge & i_nedge & ddr_q;
    assign sample_s    = pos_s | neg_s;

    assign arm_s       = (state_q == S_IDLE) && i_start && i_en;
    assign abort_s     = (state_q != S_IDLE) && !i_en;
    assign start_s     = (state_q == S_WAIT) && pos_s && ((i_dat & mask_s) == 8'h00);
    assign tmo_next_s  = tmo_q + {{(LGTIMEOUT-1){1'b0}}, 1'b1};
    assign tmo_hit_s   = (state_q == S_WAIT) && !start_s && (tmo_next_s == i_timeout);

    // In DDR the falling-edge sample right after the start bit is padding
    assign data_take_s = (state_q == S_DATA) && sample_s && !(pad_q && neg_s);
    assign word_done_s = data_take_s && (samp_cnt_q == (samples_per_word(width_q) - 6'd1));
    assign word_inc_s  = word_cnt_q + {{LGLEN{1'b0}}, 1'b1};
    assign last_word_s = word_done_s && (word_inc_s == len_q);

    assign crc_take_s  = (state_q == S_CRC) && sample_s;
    assign crc_done_s  = crc_take_s && (crc_cnt_q == (ddr_q ? 6'd31 : 6'd15));
    assign end_take_s  = (state_q == S_END) && pos_s;
    assign end_bad_s   = ((i_dat & mask_s) != mask_s);

    // Highest active lane lands in the most significant bit of each chunk
    always_comb begin
        shift_next_s = shift_q;
        case (width_q)
            W1:      shift_next_s = {shift_q[30:0], i_dat[0]};
            W4:      shift_next_s = {shift_q[27:0], i_dat[3:0]};
            default: shift_next_s = {shift_q[23:0], i_dat[7:0]};
        endcase
    end

    // Sixteen CRC accumulators: index = edge*8 + lane, edge 1 used only in DDR
    for (genvar g = 0; g < 16; g++) begin : g_crc
        localparam int LANE = g % 8;
        logic edge_hit_s;
        assign edge_hit_s    = (g >= 8) ? neg_s : pos_s;
        assign crc_step_s[g] = (data_take_s || crc_take_s) && mask_s[LANE] && edge_hit_s;

        sdrx_crc16 u_crc (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .i_clr     (arm_s),
            .i_step    (crc_step_s[g]),
            .i_bit     (i_dat[LANE]),
            .o_nonzero (crc_nz_s[g])
        );
    end

    // Next-state logic; disabling the receiver returns to idle from anywhere
    always_comb begin
        state_d = state_q;
        if (abort_s) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  state_d = arm_s ? S_WAIT : S_IDLE;
                S_WAIT: begin
                    if (start_s) begin
                        state_d = S_DATA;
                    end else if (tmo_hit_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_DATA:  state_d = last_word_s ? S_CRC : S_DATA;
                S_CRC:   state_d = crc_done_s ? S_END : S_CRC;
                S_END:   state_d = end_take_s ? S_IDLE : S_END;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath and output pulses; error flags are only meaningful alongside done
    always_comb begin
        width_d    = width_q;
        ddr_d      = ddr_q;
        len_d      = len_q;
        tmo_d      = tmo_q;
        word_cnt_d = word_cnt_q;
        samp_cnt_d = samp_cnt_q;
        crc_cnt_d  = crc_cnt_q;
        pad_d      = pad_q;
        shift_d    = shift_q;
        valid_d    = 1'b0;
        data_d     = data_q;
        last_d     = 1'b0;
        done_d     = 1'b0;
        crc_err_d  = 1'b0;
        end_err_d  = 1'b0;
        timeout_d  = 1'b0;
        busy_d     = (state_d != S_IDLE);
        if (abort_s) begin
            done_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arm_s) begin
                        width_d    = i_width;
                        ddr_d      = i_ddr;
                        len_d      = (i_len == {LGLEN{1'b0}}) ? {1'b1, {LGLEN{1'b0}}}
                                                              : {1'b0, i_len};
                        tmo_d      = {LGTIMEOUT{1'b0}};
                        word_cnt_d = {(LGLEN+1){1'b0}};
                        samp_cnt_d = 6'd0;
                        crc_cnt_d  = 6'd0;
                        pad_d      = 1'b0;
                        shift_d    = 32'h0000_0000;
                    end else begin
                        tmo_d = tmo_q;
                    end
                end
                S_WAIT: begin
                    tmo_d = tmo_next_s;
                    if (start_s) begin
                        pad_d = ddr_q;
                    end else if (tmo_hit_s) begin
                        done_d    = 1'b1;
                        timeout_d = 1'b1;
                    end else begin
                        pad_d = 1'b0;
                    end
                end
                S_DATA: begin
                    if (sample_s) begin
                        pad_d = 1'b0;
                    end else begin
                        pad_d = pad_q;
                    end
                    if (data_take_s) begin
                        shift_d = shift_next_s;
                        if (word_done_s) begin
                            samp_cnt_d = 6'd0;
                            word_cnt_d = word_inc_s;
                            valid_d    = 1'b1;
                            data_d     = shift_next_s;
                            last_d     = last_word_s;
                        end else begin
                            samp_cnt_d = samp_cnt_q + 6'd1;
                        end
                    end else begin
                        shift_d = shift_q;
                    end
                end
                S_CRC: begin
                    if (crc_take_s) begin
                        crc_cnt_d = crc_cnt_q + 6'd1;
                    end else begin
                        crc_cnt_d = crc_cnt_q;
                    end
                end
                S_END: begin
                    if (end_take_s) begin
                        done_d    = 1'b1;
                        end_err_d = end_bad_s;
                        crc_err_d = |crc_nz_s;
                    end else begin
                        done_d = 1'b0;
                    end
                end
                default: begin
                    done_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            width_q    <= 2'b00;
            ddr_q      <= 1'b0;
            len_q      <= {(LGLEN+1){1'b0}};
            tmo_q      <= {LGTIMEOUT{1'b0}};
            word_cnt_q <= {(LGLEN+1){1'b0}};
            samp_cnt_q <= 6'd0;
            crc_cnt_q  <= 6'd0;
            pad_q      <= 1'b0;
            shift_q    <= 32'h0000_0000;
            valid_q    <= 1'b0;
            data_q     <= 32'h0000_0000;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            crc_err_q  <= 1'b0;
            end_err_q  <= 1'b0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            width_q    <= width_d;
            ddr_q      <= ddr_d;
            len_q      <= len_d;
            tmo_q      <= tmo_d;
            word_cnt_q <= word_cnt_d;
            samp_cnt_q <= samp_cnt_d;
            crc_cnt_q  <= crc_cnt_d;
            pad_q      <= pad_d;
            shift_q    <= shift_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            last_q     <= last_d;
            done_q     <= done_d;
            crc_err_q  <= crc_err_d;
            end_err_q  <= end_err_d;
            timeout_q  <= timeout_d;
            busy_q     <= busy_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_data    = data_q;
    assign o_last    = last_q;
    assign o_done    = done_q;
    assign o_crc_err = crc_err_q;
    assign o_end_err = end_err_q;
    assign o_timeout = timeout_q;
    assign o_busy    = busy_q;

endmodule

// File: tb/tb_sdrx_frame.sv
// Scoreboard bench for sdrx_frame: blocks are serialised with a bench-side CRC16,
// expected words/done flags are queued as stimulus is driven and checked on output.
module tb_sdrx_frame;

    localparam int LGLEN     = 7;
    localparam int LGTIMEOUT = 20;

    logic                 i_clk = 1'b0;
    logic                 i_reset;
    logic                 i_en;
    logic                 i_start;
    logic [1:0]           i_width;
    logic                 i_ddr;
    logic [LGLEN-1:0]     i_len;
    logic [LGTIMEOUT-1:0] i_timeout;
    logic                 i_pedge;
    logic                 i_nedge;
    logic [7:0]           i_dat;
    logic                 o_valid;
    logic [31:0]          o_data;
    logic                 o_last;
    logic                 o_done;
    logic                 o_crc_err;
    logic                 o_end_err;
    logic                 o_timeout;
    logic                 o_busy;

    int          n_cmp = 0;
    int          n_err = 0;
    int          done_seen = 0;
    logic [32:0] exp_word[$];
    logic [2:0]  exp_done[$];
    logic [31:0] words[128];
    logic [32:0] ew_m;
    logic [2:0]  ed_m;

    sdrx_frame #(.LGLEN(LGLEN), .LGTIMEOUT(LGTIMEOUT)) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_en      (i_en),
        .i_start   (i_start),
        .i_width   (i_width),
        .i_ddr     (i_ddr),
        .i_len     (i_len),
        .i_timeout (i_timeout),
        .i_pedge   (i_pedge),
        .i_nedge   (i_nedge),
        .i_dat     (i_dat),
        .o_valid   (o_valid),
        .o_data    (o_data),
        .o_last    (o_last),
        .o_done    (o_done),
        .o_crc_err (o_crc_err),
        .o_end_err (o_end_err),
        .o_timeout (o_timeout),
        .o_busy    (o_busy)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: words and done flags are popped from the scoreboard
    always @(negedge i_clk) begin
        if (o_valid) begin
            if (exp_word.size() > 0) begin
                ew_m = exp_word.pop_front();
                check("word_data", {32'h0, o_data}, {32'h0, ew_m[31:0]});
                check("word_last", {63'h0, o_last}, {63'h0, ew_m[32]});
            end else begin
                check("valid_unexpected", {63'h0, o_valid}, 64'h0);
            end
        end
        if (o_done) begin
            done_seen++;
            if (exp_done.size() > 0) begin
                ed_m = exp_done.pop_front();
                check("done_flags", {61'h0, o_crc_err, o_end_err, o_timeout}, {61'h0, ed_m});
            end else begin
                check("done_unexpected", {63'h0, o_done}, 64'h0);
            end
        end
    end

    task automatic drive_sample(input logic neg, input logic [7:0] d);
        @(negedge i_clk);
        i_dat   = d;
        i_pedge = ~neg;
        i_nedge = neg;
        @(negedge i_clk);
        i_pedge = 1'b0;
        i_nedge = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 20 && done_seen < target; i++) @(negedge i_clk);
        check("done_arrived", {63'h0, (done_seen >= target)}, 64'h1);
    endtask

    task automatic arm(input logic [1:0] w, input logic ddr, input logic [LGLEN-1:0] len);
        @(negedge i_clk);
        i_start = 1'b1;
        i_width = w;
        i_ddr   = ddr;
        i_len   = len;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    // abort_mode: 0 none, 1 drop i_en mid-word, 2 assert reset right after a word
    task automatic send_block(input logic [1:0] w, input logic ddr, input int nwords,
                              input logic [LGLEN-1:0] len_code, input int flip_bit,
                              input logic [7:0] end_val, input logic exp_crc,
                              input logic exp_end, input int abort_mode, input int abort_words);
        logic [15:0] crc[16];
        logic [15:0] c;
        logic [31:0] tmp;
        logic [7:0]  d, mask;
        int lanes, spw, s, e, n, target;
        lanes = (w == 2'b00) ? 1 : ((w == 2'b01) ? 4 : 8);
        mask  = 8'((1 << lanes) - 1);
        spw   = 32 / lanes;
        for (int g = 0; g < 16; g++) crc[g] = 16'h0000;
        arm(w, ddr, len_code);
        drive_sample(1'b0, 8'hFF);
        drive_sample(1'b0, 8'hFF);
        drive_sample(1'b0, 8'($urandom) & ~mask);
        if (ddr) drive_sample(1'b1, 8'h5A);
        s = 0;
        for (int wi = 0; wi < nwords; wi++) begin
            if (abort_mode != 0 && wi == abort_words) begin
                if (abort_mode == 1) begin
                    drive_sample(1'b0, 8'($urandom));
                    drive_sample(1'b0, 8'($urandom));
                    exp_done.push_back(3'b000);
                    target = done_seen + 1;
                    @(negedge i_clk);
                    i_en = 1'b0;
                    wait_done(target);
                    check("abort_busy", {63'h0, o_busy}, 64'h0);
                    i_en = 1'b1;
                end else begin
                    check("pre_reset_valid", {63'h0, o_valid}, 64'h1);
                    #1 i_reset = 1'b1;
                    #1;
                    check("rst_mid_outs", {56'h0, o_valid, o_last, o_done, o_crc_err,
                                           o_end_err, o_timeout, o_busy, 1'b0}, 64'h0);
                    check("rst_mid_data", {32'h0, o_data}, 64'h0);
                    @(negedge i_clk);
                    i_reset = 1'b0;
                end
                return;
            end
            exp_word.push_back({(wi == nwords - 1), words[wi]});
            for (int k = 0; k < spw; k++) begin
                tmp = words[wi] << (k * lanes);
                d   = tmp[31:24] >> (8 - lanes);
                e   = ddr ? (s % 2) : 0;
                for (int l = 0; l < lanes; l++) crc[e*8+l] = crc_step(crc[e*8+l], d[l]);
                drive_sample((e == 1), d | (8'($urandom) & ~mask));
                s++;
            end
        end
        for (int i = 0; i < (ddr ? 32 : 16); i++) begin
            e = ddr ? (i % 2) : 0;
            n = ddr ? (i / 2) : i;
            d = 8'h00;
            for (int l = 0; l < lanes; l++) begin
                c = crc[e*8+l];
                if (flip_bit >= 0 && e == 0 && l == 0) c[flip_bit] = ~c[flip_bit];
                d[l] = c[15-n];
            end
            drive_sample((e == 1), d | (8'($urandom) & ~mask));
        end
        exp_done.push_back({exp_crc, exp_end, 1'b0});
        target = done_seen + 1;
        drive_sample(1'b0, end_val);
        wait_done(target);
    endtask

    initial begin
        int cyc;
        i_reset   = 1'b1;
        i_en      = 1'b1;
        i_start   = 1'b0;
        i_width   = 2'b00;
        i_ddr     = 1'b0;
        i_len     = '0;
        i_timeout = 20'd5000;
        i_pedge   = 1'b0;
        i_nedge   = 1'b0;
        i_dat     = 8'hFF;
        repeat (3) @(negedge i_clk);
        check("reset_outs", {56'h0, o_valid, o_last, o_done, o_crc_err,
                             o_end_err, o_timeout, o_busy, 1'b0}, 64'h0);
        check("reset_data", {32'h0, o_data}, 64'h0);
        i_reset = 1'b0;
        @(negedge i_clk);

        // 1-lane SDR single word, good CRC
        words[0] = 32'hDEAD_BEEF;
        send_block(2'b00, 1'b0, 1, 7'd1, -1, 8'hFF, 1'b0, 1'b0, 0, 0);
        // same block with CRC bit 5 corrupted
        send_block(2'b00, 1'b0, 1, 7'd1, 5, 8'hFF, 1'b1, 1'b0, 0, 0);

        // 4-lane DDR full 128-word block, padding nedge must be ignored
        for (int i = 0; i < 128; i++) words[i] = 32'(i);
        send_block(2'b01, 1'b1, 128, 7'd0, -1, 8'hFF, 1'b0, 1'b0, 0, 0);

        // 8-lane SDR, bad end bit on dat6
        words[0] = 32'h0123_4567;
        words[1] = 32'h89AB_CDEF;
        send_block(2'b10, 1'b0, 2, 7'd2, -1, 8'hBF, 1'b0, 1'b1, 0, 0);

        // Start-bit timeout with the bus held high
        i_timeout = 20'd100;
        i_dat     = 8'hFF;
        i_pedge   = 1'b1;
        exp_done.push_back(3'b001);
        arm(2'b00, 1'b0, 7'd1);
        cyc = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge i_clk);
            if (o_done) begin
                cyc = i;
                break;
            end
        end
        check("tmo_cycle", 64'(cyc), 64'd100);
        @(negedge i_clk);
        check("tmo_busy", {63'h0, o_busy}, 64'h0);
        i_pedge   = 1'b0;
        i_timeout = 20'd5000;

        // Abort after 3 of 8 words
        for (int i = 0; i < 8; i++) words[i] = $urandom;
        send_block(2'b01, 1'b0, 8, 7'd8, -1, 8'hFF, 1'b0, 1'b0, 1, 3);
        repeat (5) @(negedge i_clk);

        // Reset mid-block right after the second word
        send_block(2'b10, 1'b0, 4, 7'd4, -1, 8'hFF, 1'b0, 1'b0, 2, 2);

        repeat (10) @(negedge i_clk);
        check("word_queue_empty", 64'(exp_word.size()), 64'd0);
        check("done_queue_empty", 64'(exp_done.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
